// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter (LSB first) fed by a small write FIFO.
//   clk      : system clock, rising edge
//   reset    : asynchronous active-high reset; flushes FIFO and aborts any frame
//   wr_en    : push wr_data this cycle (dropped with an overflow pulse when full)
//   wr_data  : byte to transmit
//   full     : FIFO holds FIFO_DEPTH bytes
//   level    : bytes waiting in the FIFO, excluding the byte being shifted
//   busy     : a frame is being shifted out
//   tx_done  : one-cycle pulse after each stop bit completes
//   overflow : one-cycle pulse after a dropped write
//   uart_tx  : registered serial line, idles high
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 12,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wr_en,
    input  logic [7:0]                     wr_data,
    output logic                           full,
    output logic [$clog2(FIFO_DEPTH):0]    level,
    output logic                           busy,
    output logic                           tx_done,
    output logic                           overflow,
    output logic                           uart_tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d, done_q, done_d, ovf_q;
    logic          empty, push, pop, last;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign level    = wr_ptr_q - rd_ptr_q;
    assign full     = level == (AW+1)'(FIFO_DEPTH);
    assign empty    = wr_ptr_q == rd_ptr_q;
    assign push     = wr_en && !full;
    assign last     = cnt_q == CW'(CLKS_PER_BIT - 1);
    assign busy     = state_q != IDLE;
    assign tx_done  = done_q;
    assign overflow = ovf_q;
    assign uart_tx  = tx_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = (state_q == IDLE || last) ? '0 : cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE: if (!empty) begin
                pop     = 1'b1;
                shift_d = mem_q[rd_ptr_q[AW-1:0]];
                tx_d    = 1'b0;
                state_d = START;
            end
            START: if (last) begin
                state_d = DATA;
                bit_d   = 3'd0;
                tx_d    = shift_q[0];
            end
            // tx_d looks one bit ahead so the line stays registered.
            DATA: if (last) begin
                shift_d = shift_q >> 1;
                bit_d   = bit_q + 3'd1;
                tx_d    = (bit_q == 3'd7) ? 1'b1 : shift_q[1];
                state_d = (bit_q == 3'd7) ? STOP : DATA;
            end
            // A queued byte starts immediately, giving gap-free back-to-back frames.
            STOP: if (last) begin
                done_d = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q[AW-1:0]];
                    tx_d    = 1'b0;
                    state_d = START;
                end else begin
                    tx_d    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= push ? wr_ptr_q + 1'b1 : wr_ptr_q;
            rd_ptr_q <= pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            done_q   <= done_d;
            ovf_q    <= wr_en && full;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed self-checking bench for uart_tx_fifo (12 clocks/bit, depth 4).
module tb_uart_tx_fifo;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full, busy, tx_done, overflow, uart_tx;
    logic [2:0] level;
    int         checks = 0;
    int         errors = 0;

    uart_tx_fifo #(.CLKS_PER_BIT(12), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .level(level), .busy(busy), .tx_done(tx_done),
        .overflow(overflow), .uart_tx(uart_tx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // Entered at the negedge just after the load edge; leaves at the negedge after the final stop edge.
    task automatic frame(input logic [7:0] b);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < 12; c++) begin
                chk("frame_bit", uart_tx, f[k]);
                if (k != 0 || c != 0) chk("no_early_done", tx_done, 1'b0);
                @(negedge clk);
            end
        end
        chk("tx_done", tx_done, 1'b1);
    endtask

    task automatic wait_done(input int lim);
        int n;
        n = 0;
        while (!tx_done && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("wait_done", tx_done, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 reset = 1'b1;
        #1;
        chk("rst_outputs", {uart_tx, busy, tx_done, overflow, full, level}, {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0});
        #1 reset = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            chk("idle", {uart_tx, busy, level}, {1'b1, 1'b0, 3'd0});
        end

        write(8'h05);
        chk("single_queued", {uart_tx, busy, level}, {1'b1, 1'b0, 3'd1});
        @(negedge clk);
        chk("single_loaded", {busy, level}, {1'b1, 3'd0});
        frame(8'h05);
        chk("single_busy_drop", busy, 1'b0);
        @(negedge clk);
        chk("single_done_pulse", tx_done, 1'b0);

        wr_en = 1'b1; wr_data = 8'hA5;
        @(negedge clk);
        wr_data = 8'h3C;
        @(negedge clk);
        wr_en = 1'b0;
        chk("b2b_level", {busy, level}, {1'b1, 3'd1});
        frame(8'hA5);
        chk("b2b_still_busy", busy, 1'b1);
        frame(8'h3C);
        chk("b2b_end_busy", busy, 1'b0);
        @(negedge clk);

        write(8'h55);
        @(negedge clk);
        chk("ovf_busy", {busy, level}, {1'b1, 3'd0});
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1;
            wr_data = 8'h10 + 8'(i);
            @(negedge clk);
            chk("ovf_level", level, (i < 4) ? i + 1 : 4);
            chk("ovf_full", full, i >= 3);
            chk("ovf_pulse", overflow, i == 4);
        end
        wr_en = 1'b0;
        @(negedge clk);
        chk("ovf_pulse_end", {overflow, full, level}, {1'b0, 1'b1, 3'd4});
        wait_done(150);
        chk("ovf_pop_level", level, 3);
        frame(8'h10);
        frame(8'h11);
        frame(8'h12);
        frame(8'h13);
        chk("ovf_drain", {busy, full, level}, {1'b0, 1'b0, 3'd0});
        @(negedge clk);

        wr_en = 1'b1; wr_data = 8'hFF;
        @(negedge clk);
        wr_data = 8'h81;
        @(negedge clk);
        wr_data = 8'h42;
        @(negedge clk);
        wr_en = 1'b0;
        repeat (50) @(negedge clk);
        chk("mid_frame", {uart_tx, busy, level}, {1'b1, 1'b1, 3'd2});
        #2 reset = 1'b1;
        #1;
        chk("async_reset", {uart_tx, busy, tx_done, overflow, full, level}, {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0});
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            chk("post_reset_idle", {uart_tx, busy, level}, {1'b1, 1'b0, 3'd0});
        end
        write(8'h5A);
        chk("recover_queued", {uart_tx, level}, {1'b1, 3'd1});
        @(negedge clk);
        frame(8'h5A);
        chk("recover_end", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- UART transmitter, 8N1 (8 data bits, no parity, one stop bit), LSB first, with a small write FIFO.
- Drives the processor's uart_tx pin and is fed by the memory-mapped UART peripheral's write strobe.
- Complements the receive path on uart_rx. Uses the same bit timing of 12 clocks per bit (120 ns at a 10 ns clock).

Parameters:
- CLKS_PER_BIT, 12, clock cycles per UART bit; must be >= 2.
- FIFO_DEPTH, 4, number of buffered bytes; must be a power of 2 and >= 2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- wr_en  input  1  push wr_data into the FIFO this cycle.
- wr_data  input  8  byte to transmit.
- full  output  1  FIFO holds FIFO_DEPTH entries.
- level  output  clog2(FIFO_DEPTH)+1  number of FIFO entries, not counting the byte in flight.
- busy  output  1  high while a frame is being shifted (state != IDLE).
- tx_done  output  1  one-cycle pulse when a stop bit completes.
- overflow  output  1  one-cycle pulse when a write is dropped.
- uart_tx  output  1  serial line; idles high.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - Outputs: uart_tx=1, busy=0, tx_done=0, overflow=0, full=0, level=0.
  - FIFO is flushed, FSM goes to IDLE, bit counter and cycle counter are cleared.
- FIFO:
  - Circular buffer with rd_ptr/wr_ptr, one bit wider than the index; wrap-around by modulo FIFO_DEPTH.
  - Write accepted when wr_en=1 and full=0.
  - wr_en=1 while full=1: write dropped and overflow pulses for 1 cycle. This holds even if a pop happens in the same cycle (full is evaluated before the pop).
  - Simultaneous accepted write and pop: level unchanged.
- FSM states and transitions:
  - IDLE: uart_tx=1.
    - If FIFO is non-empty on an edge: load the head byte into an 8-bit shift register, pop, go to START.
  - START: uart_tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: uart_tx=shift[0] for CLKS_PER_BIT cycles per bit, shift right after each bit, 8 bits in total, then go to STOP.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles. On the final cycle, tx_done is asserted for the following cycle, then:
    - FIFO non-empty: load and pop, go directly to START. No idle gap; back-to-back frames are exactly 10*CLKS_PER_BIT cycles apart.
    - FIFO empty: go to IDLE.
- uart_tx is driven from a register (glitch-free).
- Latency:
  - Write sampled at edge N with FIFO empty and FSM in IDLE.
  - Entry visible after edge N; load/pop at edge N+1; uart_tx falls after edge N+1.
  - uart_tx low for exactly CLKS_PER_BIT cycles.
- Frame length: exactly 10*CLKS_PER_BIT cycles (120 cycles = 1200 ns at default).
- Cycle counter: counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary. Bit index counts 0..7.
- busy rises on the load edge and falls on the edge entering IDLE.
- A byte written while busy waits in the FIFO; the byte in flight is never corrupted by writes.

Test Plan:
1. Idle check: after reset (held 2 ns, then released) with no writes -> uart_tx=1, busy=0 and level=0 for 1000 cycles.
2. Single byte: write 0x05 -> uart_tx 1 cycle later holds, each for 12 cycles: 0, then 1,0,1,0,0,0,0,0, then 1. tx_done pulses once at cycle 120 of the frame. busy then drops.
3. Back-to-back: write 0xA5 and 0x3C on consecutive cycles ->
   - Frame bits 0,1,0,1,0,0,1,0,1,1 then 0,0,0,1,1,1,1,0,0,1.
   - Second start bit begins the cycle after the first stop bit ends.
   - tx_done pulses 120 cycles apart.
4. Full/overflow: while busy, write 0x10..0x14 on 5 consecutive cycles ->
   - First 4 accepted; level reaches 4 and full=1.
   - Write of 0x14 dropped with a 1-cycle overflow pulse.
   - Line then carries 0x10..0x13 in order.
5. Reset mid-frame: assert reset during DATA bit 3 of 0xFF with 2 bytes queued ->
   - uart_tx=1 immediately (asynchronous), level=0, busy=0.
   - After release, no frame is sent until the next write.
